// File: rtl/fpga_exit_reporter_pkg.sv
// Shared types and constants for the exit reporter: FSM state enums,
// message length, ASCII constants and the nibble-to-hex-digit helper.
// No ports; imported by fpga_uart_tx and fpga_exit_reporter.
package fpga_exit_reporter_pkg;

  // Top-level sequencing FSM.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BYTE,
    ST_DONE
  } state_e;

  // Byte transmitter FSM.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam int         MSG_LEN  = 15;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_X  = 8'h58;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/fpga_uart_tx.sv
// 8N1 byte transmitter, LSB first, idle high; each bit lasts CLK_DIV cycles.
// Ports: clk_i, rst_ni (sync, active-low), valid_i/data_i/ready_o byte
// handshake, done_o one-cycle pulse near frame end, tx_o registered line.
// Latency: start bit on tx_o the cycle after a valid_i&&ready_o handshake.
// Backpressure: ready_o is high when idle and in the last stop-bit cycle,
// so a byte offered then starts its frame with no idle gap.
module fpga_uart_tx
  import fpga_exit_reporter_pkg::*;
#(
  parameter int CLK_DIV = 130
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(CLK_DIV - 2);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  assign ready_o = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
  // Pulses one cycle before the stop bit ends so the sequencer can present
  // the next byte in the stop bit's last cycle (hence CLK_DIV >= 2).
  assign done_o  = (state_q == TX_STOP) && (cnt_q == CNT_PEN);
  assign tx_o    = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        if (valid_i) begin
          state_d = TX_START;
          cnt_d   = '0;
          shreg_d = data_i;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (valid_i) begin
            state_d = TX_START;
            shreg_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/fpga_exit_reporter.sv
// Captures the exit value on the first exit_valid rise and sends it once over
// UART as "EXIT=XXXXXXXX\r\n"; drives a pass/fail status LED.
// Ports: clk_i, rst_ni (sync, active-low), exit_valid_i/exit_value_i from the
// system; uart_tx_o, busy_o, done_o (sticky), status_led_o, all registered.
// Latency: start bit and busy_o one cycle after the capture edge; done_o
// 1 + 150*CLK_DIV cycles after it. No backpressure: later events are dropped.
// Option: define FPGA_EXIT_REPORTER_BLINK_EN to blink the LED on failure;
// otherwise a failure leaves the LED off.
module fpga_exit_reporter
  import fpga_exit_reporter_pkg::*;
#(
  parameter int CLK_DIV            = 130,
  parameter int BLINK_COUNT_LENGTH = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        status_led_o
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] value_q, value_d;
  logic        exit_valid_q;
  logic        busy_q, done_q, led_q;
  logic        led_d;

  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;
  logic [7:0]  tx_char;
  logic        capture_evt;

  // History starts at 0, so a level already high after reset is an event.
  assign capture_evt = exit_valid_i & ~exit_valid_q;

  // Character for the current message index.
  always_comb begin
    tx_char = ASCII_LF;
    case (idx_q)
      4'd0:    tx_char = ASCII_E;
      4'd1:    tx_char = ASCII_X;
      4'd2:    tx_char = ASCII_I;
      4'd3:    tx_char = ASCII_T;
      4'd4:    tx_char = ASCII_EQ;
      4'd5:    tx_char = hex2ascii(value_q[31:28]);
      4'd6:    tx_char = hex2ascii(value_q[27:24]);
      4'd7:    tx_char = hex2ascii(value_q[23:20]);
      4'd8:    tx_char = hex2ascii(value_q[19:16]);
      4'd9:    tx_char = hex2ascii(value_q[15:12]);
      4'd10:   tx_char = hex2ascii(value_q[11:8]);
      4'd11:   tx_char = hex2ascii(value_q[7:4]);
      4'd12:   tx_char = hex2ascii(value_q[3:0]);
      4'd13:   tx_char = ASCII_CR;
      default: tx_char = ASCII_LF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    value_d  = value_q;
    tx_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture_evt) begin
          state_d = ST_SEND;
          idx_d   = '0;
          value_d = exit_value_i;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_BYTE: begin
        // tx_done arrives one cycle before the stop bit ends, so SEND hands
        // over the next character exactly in the stop bit's last cycle.
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef FPGA_EXIT_REPORTER_BLINK_EN
  logic [BLINK_COUNT_LENGTH-1:0] blink_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  always_comb begin
    led_d = 1'b0;
    if (state_q == ST_DONE) begin
      led_d = (value_q == '0) ? 1'b1 : blink_q[BLINK_COUNT_LENGTH-1];
    end
  end
`else
  always_comb begin
    led_d = (state_q == ST_DONE) && (value_q == '0);
  end
`endif

  // Flags lag the state by one cycle so they line up with the UART line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      value_q      <= '0;
      exit_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      value_q      <= value_d;
      exit_valid_q <= exit_valid_i;
      busy_q       <= (state_q == ST_SEND) || (state_q == ST_WAIT_BYTE);
      done_q       <= (state_q == ST_DONE);
      led_q        <= led_d;
    end
  end

  fpga_uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_uart_tx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(tx_valid),
    .data_i (tx_char),
    .ready_o(tx_ready),
    .done_o (tx_done),
    .tx_o   (uart_tx_o)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign status_led_o = led_q;

endmodule
